// File: rtl/led_scan_capture.sv
// LED matrix scan capture: synchronizes the scanned row/column pins, samples each settled
// scan vector once, ORs lit pixels into a per-column accumulator over a fixed window, and
// publishes the accumulated image to a front buffer readable one column at a time.
// Optional feature: define SCAN_CAPTURE_COLLISION_EN to enable the sticky collision flag.
module led_scan_capture #(
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned FRAME_CYC = 1024
) (
  input  logic        CLK,
  input  logic        Clear,
  input  logic [7:0]  DATA_R,
  input  logic [7:0]  DATA_G,
  input  logic [7:0]  DATA_B,
  input  logic [2:0]  S,
  input  logic        COMM,
  input  logic [2:0]  rd_col,
  output logic [23:0] rd_rgb,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        collision
);

  localparam logic [3:0]  LP_SETTLE    = 4'(SETTLE);
  localparam logic [3:0]  LP_SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [15:0] LP_TC        = 16'(FRAME_CYC - 1);

  // Scan vector layout: {R[7:0], G[7:0], B[7:0], S[2:0], COMM}
  logic [27:0] w_pins;
  logic [27:0] r_sync1, r_sync2, r_prev;
  logic [3:0]  r_stab;
  logic [15:0] r_win;
  logic [23:0] r_acc   [8];
  logic [23:0] r_front [8];
  logic [23:0] w_acc_nxt [8];
  logic [23:0] r_rd_rgb;
  logic        r_frame_done;
  logic [7:0]  r_frame_cnt;

  logic        w_change;
  logic        w_sample;
  logic        w_accept;
  logic        w_tc;
  logic [2:0]  w_col;
  logic [23:0] w_rgb;

  assign w_pins   = {DATA_R, DATA_G, DATA_B, S, COMM};
  assign w_change = (r_sync2 != r_prev);
  // Fires only on the SETTLE-1 -> SETTLE transition, so one sample per stable period
  assign w_sample = !w_change && (r_stab == LP_SETTLE_M1);
  assign w_accept = w_sample && r_sync2[0];
  assign w_col    = r_sync2[3:1];
  // Row data is active-low at the pins; store lit pixels as 1
  assign w_rgb    = ~r_sync2[27:4];
  assign w_tc     = (r_win == LP_TC);

  // Two-flop synchronizer plus a delayed copy for change detection
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Stability counter: restarts on any change, saturates at SETTLE
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_stab <= '0;
    end else if (w_change) begin
      r_stab <= '0;
    end else if (r_stab != LP_SETTLE) begin
      r_stab <= r_stab + 4'd1;
    end
  end

  // Free-running window counter
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_win <= '0;
    end else if (w_tc) begin
      r_win <= '0;
    end else begin
      r_win <= r_win + 16'd1;
    end
  end

  // Accumulator with this cycle's sample merged in, so a terminal-count sample reaches front
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_acc_nxt[i] = r_acc[i];
      if (w_accept && (w_col == 3'(i))) begin
        w_acc_nxt[i] = r_acc[i] | w_rgb;
      end
    end
  end

  // Accumulate samples; at terminal count publish to front and restart from zero
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 8; i++) begin
        r_acc[i]   <= '0;
        r_front[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_tc) begin
          r_front[i] <= w_acc_nxt[i];
          r_acc[i]   <= '0;
        end else begin
          r_acc[i]   <= w_acc_nxt[i];
        end
      end
    end
  end

  // Registered outputs: read port returns pre-update front on a coincident update
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_rd_rgb     <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_rd_rgb     <= r_front[rd_col];
      r_frame_done <= w_tc;
      if (w_tc) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign rd_rgb     = r_rd_rgb;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

`ifdef SCAN_CAPTURE_COLLISION_EN
  logic w_coll_hit;
  logic r_coll;

  // Two or more colours lit on the same row bit of one accepted sample
  assign w_coll_hit = w_accept &&
                      (|((w_rgb[23:16] & w_rgb[15:8]) |
                         (w_rgb[23:16] & w_rgb[7:0])  |
                         (w_rgb[15:8]  & w_rgb[7:0])));

  // Sticky flag, cleared the cycle after frame_done; a new hit wins over the clear
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_coll <= 1'b0;
    end else if (w_coll_hit) begin
      r_coll <= 1'b1;
    end else if (r_frame_done) begin
      r_coll <= 1'b0;
    end
  end

  assign collision = r_coll;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_led_scan_capture.sv
// Bench for led_scan_capture: random scan segments plus directed scenarios, checked every
// cycle against a window-level model (samples binned by edge number into windows).
module tb_led_scan_capture;

  localparam int unsigned ST   = 4;
  localparam int unsigned FC   = 64;
  localparam int unsigned MAXW = 320;
`ifdef SCAN_CAPTURE_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Clear = 1'b0;
  logic [7:0]  DATA_R = 8'hFF;
  logic [7:0]  DATA_G = 8'hFF;
  logic [7:0]  DATA_B = 8'hFF;
  logic [2:0]  S = 3'd0;
  logic        COMM = 1'b0;
  logic [2:0]  rd_col = 3'd0;
  logic [23:0] rd_rgb;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        collision;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_edge = 0;
  int unsigned fd_count = 0;
  logic [2:0]  last_col = 3'd0;
  logic [27:0] last_vec = '0;

  // Model: OR of accepted samples per window and column; first colliding sample edge per window
  logic [23:0] win_acc [MAXW][8];
  int unsigned coll_first [MAXW];

  int unsigned mon_e, mon_done;
  logic [23:0] mon_er;
  logic        mon_coll;
  logic [23:0] rv;

  led_scan_capture #(
    .SETTLE    (ST),
    .FRAME_CYC (FC)
  ) u_dut (
    .CLK        (CLK),
    .Clear      (Clear),
    .DATA_R     (DATA_R),
    .DATA_G     (DATA_G),
    .DATA_B     (DATA_B),
    .S          (S),
    .COMM       (COMM),
    .rd_col     (rd_col),
    .rd_rgb     (rd_rgb),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .collision  (collision)
  );

  always #5 CLK = ~CLK;

  // Edge index since reset release: value seen after edge k is k+1
  always @(posedge CLK or negedge Clear) begin
    if (!Clear) n_edge <= 0;
    else        n_edge <= n_edge + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < int'(MAXW); w++) begin
      for (int c = 0; c < 8; c++) win_acc[w][c] = '0;
      coll_first[w] = 32'hFFFF_FFFF;
    end
  endtask

  task automatic step();
    rd_col = 3'($urandom_range(7));
    @(posedge CLK);
    #1;
  endtask

  // Drive one held pin vector; a long hold samples once, SETTLE+2 edges after it starts
  task automatic seg(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [2:0] s, input logic c, input int unsigned len);
    int unsigned se, w;
    logic [23:0] rgb;
    se  = n_edge + ST + 2;
    w   = se / FC;
    rgb = {~r, ~g, ~b};
    DATA_R = r; DATA_G = g; DATA_B = b; S = s; COMM = c;
    last_vec = {r, g, b, s, c};
    if (len > ST && c && w < MAXW) begin
      win_acc[w][s] = win_acc[w][s] | rgb;
      if (COLL_EN && (|((rgb[23:16] & rgb[15:8]) | (rgb[23:16] & rgb[7:0]) |
                        (rgb[15:8] & rgb[7:0]))) && se < coll_first[w])
        coll_first[w] = se;
    end
    repeat (len) step();
  endtask

  task automatic idle(input int unsigned len);
    seg(8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b0, len);
  endtask

  task automatic rnd_seg();
    logic [7:0] r, g, b;
    logic [2:0] s;
    logic c;
    int unsigned len;
    do begin
      r = 8'($urandom | $urandom | $urandom);
      g = 8'($urandom | $urandom | $urandom);
      b = 8'($urandom | $urandom | $urandom);
      s = 3'($urandom_range(7));
      c = ($urandom_range(9) < 7);
    end while ({r, g, b, s, c} == last_vec);
    if ($urandom_range(1) == 1) len = $urandom_range(ST + 12, ST + 3);
    else                        len = $urandom_range(ST, 1);
    seg(r, g, b, s, c, len);
  endtask

  task automatic read_col(input logic [2:0] c, output logic [23:0] v);
    rd_col = c;
    @(posedge CLK);
    #1;
    v = rd_rgb;
  endtask

  task automatic wait_frame(input string tag);
    int unsigned k = 0;
    do begin
      step();
      k++;
    end while (!frame_done && k < 2 * FC);
    if (!frame_done) check_eq(tag, 32'd0, 32'd1);
  endtask

  // Assert reset, check outputs are cleared at once, then release into a fresh model
  task automatic do_reset(input string tag);
    DATA_R = 8'hFF; DATA_G = 8'hFF; DATA_B = 8'hFF; S = 3'd0; COMM = 1'b0;
    Clear = 1'b0;
    #1;
    check_eq({tag, "_rd_rgb"}, 32'(rd_rgb), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check_eq({tag, "_collision"}, 32'(collision), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    model_clear();
    last_vec = {8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b0};
    Clear = 1'b1;
  endtask

  // Per-cycle monitor against the window model
  always @(negedge CLK) begin
    if (!Clear) begin
      fd_count = 0;
    end else if (n_edge != 0) begin
      mon_e    = n_edge - 1;
      mon_done = mon_e / FC;
      mon_er   = '0;
      if (mon_done > 0 && mon_done <= MAXW) mon_er = win_acc[mon_done - 1][last_col];
      mon_coll = COLL_EN && (coll_first[mon_e / FC] <= mon_e);
      check_eq("rd_rgb", 32'(rd_rgb), 32'(mon_er));
      check_eq("frame_done", 32'(frame_done), 32'((n_edge % FC) == 0));
      check_eq("frame_cnt", 32'(frame_cnt), (n_edge / FC) % 256);
      check_eq("collision", 32'(collision), 32'(mon_coll));
      if (frame_done) fd_count++;
    end
    last_col = rd_col;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    model_clear();
    @(posedge CLK);
    #1;
    do_reset("rst0");
    idle(10);

    // Random segments, long and glitch-length
    repeat (400) rnd_seg();
    idle(12);

    // Single lit blue pixel on column 3
    do_reset("rst1");
    idle(10);
    wait_frame("t1_align");
    seg(8'hFF, 8'hFF, 8'h7F, 3'd3, 1'b1, 20);
    idle(10);
    wait_frame("t1_wait");
    for (int c = 0; c < 8; c++) begin
      read_col(3'(c), rv);
      check_eq($sformatf("t1_col%0d", c), 32'(rv), (c == 3) ? 32'h000080 : 32'd0);
    end

    // Two samples OR-merged on column 2
    wait_frame("t2_align");
    seg(8'hFF, 8'hFE, 8'hFF, 3'd2, 1'b1, 10);
    seg(8'hFE, 8'hFF, 8'hFF, 3'd2, 1'b1, 10);
    idle(10);
    wait_frame("t2_wait");
    read_col(3'd2, rv);
    check_eq("t2_col2", 32'(rv), 32'h010100);

    // Glitch shorter than SETTLE is never sampled
    wait_frame("t3_align");
    seg(8'h00, 8'hFF, 8'hFF, 3'd1, 1'b1, 3);
    idle(10);
    wait_frame("t3_wait");
    for (int c = 0; c < 8; c++) begin
      read_col(3'(c), rv);
      check_eq($sformatf("t3_col%0d", c), 32'(rv), 32'd0);
    end
    check_eq("t3_collision", 32'(collision), 32'd0);

    // Sample landing exactly on terminal count
    k = 0;
    while (((n_edge + ST + 2) % FC) != FC - 1 && k < FC) begin
      step();
      k++;
    end
    seg(8'hFF, 8'hEF, 8'hFF, 3'd6, 1'b1, ST + 3);
    check_eq("t5_frame_done", 32'(frame_done), 32'd1);
    read_col(3'd6, rv);
    check_eq("t5_front", 32'(rv), 32'h001000);
    idle(5);
    wait_frame("t5_wait");
    read_col(3'd6, rv);
    check_eq("t5_next_zero", 32'(rv), 32'd0);

    // Collision on column 5: held until the cycle after the next frame_done
    seg(8'hF7, 8'hF7, 8'hFF, 3'd5, 1'b1, 10);
    idle(5);
    check_eq("t6_coll_set", 32'(collision), 32'(COLL_EN));
    wait_frame("t6_wait");
    check_eq("t6_coll_fd", 32'(collision), 32'(COLL_EN));
    read_col(3'd5, rv);
    check_eq("t6_front", 32'(rv), 32'h080800);
    check_eq("t6_coll_clr", 32'(collision), 32'd0);

    // Reset mid-window with pending data and a set collision flag
    seg(8'hF7, 8'hF7, 8'hFF, 3'd5, 1'b1, 10);
    idle(10);
    do_reset("t6_midrst");
    idle(10);
    repeat (2 * FC) step();

    // 257 empty windows: frame_cnt wraps to 1
    do_reset("t4_rst");
    repeat (257 * FC) step();
    @(negedge CLK);
    #1;
    check_eq("t4_fd_count", fd_count, 32'd257);
    check_eq("t4_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
